seg7_scan: RTL
==============

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clk cycles each digit is active; minimum 4.
REQ-002 Parameter GUARD, default 16, cycles at the start of each digit slot with all anodes off (anti-ghosting); must be less than SCAN_DIV.
REQ-003 Parameter BLINK_FRAMES, default 125, full 4-digit frames per blink half-period; minimum 1.
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 dig0  input  4  rightmost digit code (0-9 numeral, 10 blank, 11 dash, 12-15 blank).
REQ-007 dig1  input  4  digit code, second from right.
REQ-008 dig2  input  4  digit code, third from right.
REQ-009 dig3  input  4  leftmost digit code.
REQ-010 blink_mask  input  4  bit i set: digit i blinks; 4'b0000 disables blinking.
REQ-011 an  output  4  anode enables, active-low; bit i drives digit i.
REQ-012 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-013 dp  output  1  decimal point, active-low; always 1.

Function
REQ-014 scan_cnt SHALL count 0..SCAN_DIV-1 and wrap; tick = (scan_cnt == SCAN_DIV-1).
REQ-015 idx (2 bits) SHALL advance 0->1->2->3->0 on each tick, taking effect the cycle after the tick.
REQ-016 On a tick with idx==3, dig0..dig3 SHALL be captured into shadow registers; displayed values come only from the shadows, so an input change appears at the next frame start and never mid-frame.
REQ-017 an, seg and dp SHALL be registered; they reflect idx, scan_cnt, shadows and blink phase of the previous cycle (1-cycle latency).
REQ-018 an SHALL be 4'b1111 while scan_cnt < GUARD; otherwise an SHALL be all ones except bit idx = 0.
REQ-019 Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, 11=0111111, 10 and 12-15=1111111.
REQ-020 Blink: frame_cnt SHALL increment on each tick with idx==3; on reaching BLINK_FRAMES-1 it wraps to 0 and phase toggles (on<->off).
REQ-021 While phase is off and blink_mask[idx]=1, an SHALL be 4'b1111 for that slot; unmasked digits display normally.
REQ-022 When blink_mask==0, frame_cnt SHALL be held at 0 and phase forced to on in the same cycle; when a mask is re-applied, blinking starts with a full on half-period.
REQ-023 Changes to blink_mask SHALL take effect immediately (not frame-synchronised).
REQ-024 No handshake; dig inputs are sampled only at REQ-016 captures.

Reset
REQ-025 While rst=1, the block SHALL drive an=4'b1111, seg=7'b1111111, dp=1, scan_cnt=0, idx=0, frame_cnt=0, phase=on, and all shadows=10 (blank).
REQ-026 Assertion of rst mid-frame SHALL clear the block asynchronously; after release, scanning restarts at idx 0 and the display stays blank until the first capture (about 4*SCAN_DIV cycles).

Structure
REQ-027 Codes CODE_BLANK=10 and CODE_DASH=11 and the segment patterns of REQ-019 SHALL live in the shared display constants package, also used by the game FSM.
REQ-028 The decode SHALL be a combinational sub-module seg7_decode (4-bit code in, 7-bit seg out), instantiated once on the selected shadow.

Verification (SCAN_DIV=8, GUARD=2, BLINK_FRAMES=2)
REQ-029 Reset, then dig3..dig0=11,3,10,0 held -> first frame blank; from the second frame slot0 seg=1000000 with an=1110, slot1 blank, slot2 seg=0110000 with an=1011, slot3 seg=0111111 with an=0111; an=1111 for the first 2 cycles of every slot.
REQ-030 Change dig0 from 0 to 8 while idx=1 -> slot0 still shows 0 until the frame after the capture, then shows 0000000; no partial frame.
REQ-031 blink_mask=4'b1100, all digits 8 -> digits 2 and 3 alternate 2 frames lit and 2 frames dark; digits 0 and 1 are lit every frame.
REQ-032 blink_mask forced to 0 while phase is off -> digits lit from the next slot; re-apply 4'b1100 -> 2 full frames lit before the first dark period.
REQ-033 Assert rst for 1 cycle mid-slot2 -> an=1111 and seg=1111111 asynchronously; after release scanning starts at idx 0 with a blank frame.
REQ-034 dig codes 12-15 -> seg=1111111; dp=1 in all tests.

Source files
------------

// File: rtl/seg7_scan_pkg.sv
// Shared display constants: digit codes and active-low segment patterns.
// Also used by the game FSM, so keep the names stable.
package seg7_scan_pkg;

    localparam logic [3:0] CODE_BLANK = 4'd10;
    localparam logic [3:0] CODE_DASH  = 4'd11;

    // Patterns are {g,f,e,d,c,b,a}, low = segment lit.
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] AN_OFF   = 4'b1111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to 7-segment decoder.
// Codes 10 and 12-15 produce a dark digit.
module seg7_decode
    import seg7_scan_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (code_i)
            4'd0:      seg_o = SEG_0;
            4'd1:      seg_o = SEG_1;
            4'd2:      seg_o = SEG_2;
            4'd3:      seg_o = SEG_3;
            4'd4:      seg_o = SEG_4;
            4'd5:      seg_o = SEG_5;
            4'd6:      seg_o = SEG_6;
            4'd7:      seg_o = SEG_7;
            4'd8:      seg_o = SEG_8;
            4'd9:      seg_o = SEG_9;
            CODE_DASH: seg_o = SEG_DASH;
            default:   seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment scanner with guard band,
// frame-synchronous digit capture and per-digit blinking.
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int GUARD        = 16,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dig0,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
    input  logic [3:0] blink_mask,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

    localparam logic PH_OFF = 1'b0;
    localparam logic PH_ON  = 1'b1;

    logic [CW-1:0]   scan_cnt_q, scan_cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic            phase_q, phase_d;
    logic [3:0][3:0] shadow_q, shadow_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q;

    logic tick;
    logic frame_end;
    logic hide;

    seg7_decode u_decode (
        .code_i (shadow_q[idx_q]),
        .seg_o  (seg_d)
    );

    always_comb begin
        tick       = (scan_cnt_q == CNT_LAST);
        frame_end  = tick && (idx_q == 2'd3);
        scan_cnt_d = tick ? '0 : scan_cnt_q + CW'(1);
        idx_d      = tick ? idx_q + 2'd1 : idx_q;
        shadow_d   = frame_end ? {dig3, dig2, dig1, dig0} : shadow_q;

        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        // An empty mask parks the blink timer so re-enabling starts lit.
        if (blink_mask == 4'b0000) begin
            frame_cnt_d = '0;
            phase_d     = PH_ON;
        end else if (frame_end) begin
            if (frame_cnt_q == FRM_LAST) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end

        hide = (scan_cnt_q < GUARD_C) ||
               ((phase_q == PH_OFF) && blink_mask[idx_q]);
        an_d = hide ? AN_OFF : ~(4'b0001 << idx_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            idx_q       <= 2'd0;
            frame_cnt_q <= '0;
            phase_q     <= PH_ON;
            shadow_q    <= {4{CODE_BLANK}};
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
            shadow_q    <= shadow_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= 1'b1;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
